zb_probe_router: RTL and testbench

// Parametrised successor to the fixed test mux/demux fabric around the ZigBee TX/RX chain.

---
 rtl/zb_probe_router_if.sv | 29 ++
 rtl/zb_probe_router.sv | 149 ++++++++++++++
 tb/tb_zb_probe_router.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zb_probe_router_if.sv
// Probe-router bus: serial config, probe inputs, read-out handshake and status.
// The router owns the out* signals; whoever drives stimulus owns the in* signals.
interface zb_probe_router_if #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 4
);
    logic                      inCfgShift;
    logic                      inCfgData;
    logic                      inCfgLoad;
    logic [NUM_CH*WIDTH-1:0]   inProbe;
    logic [NUM_CH-1:0]         inProbeValid;
    logic                      inReadEnable;
    logic [WIDTH-1:0]          outData;
    logic                      outValid;
    logic                      outEmpty;
    logic                      outFull;
    logic                      outDone;
    logic                      outCfgEcho;

    modport master (
        output inCfgShift, inCfgData, inCfgLoad, inProbe, inProbeValid, inReadEnable,
        input  outData, outValid, outEmpty, outFull, outDone, outCfgEcho
    );

    modport slave (
        input  inCfgShift, inCfgData, inCfgLoad, inProbe, inProbeValid, inReadEnable,
        output outData, outValid, outEmpty, outFull, outDone, outCfgEcho
    );
endinterface

// File: rtl/zb_probe_router.sv
// Test probe router: picks one of NUM_CH probe buses under a serially loaded config and
// either mirrors it live (registered) or captures DEPTH qualified samples for read-out.
module zb_probe_router #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 16
) (
    input  logic              inClock,
    input  logic              inReset,
    zb_probe_router_if.slave  prb
);
    localparam int SELW  = $clog2(NUM_CH);
    localparam int CFG_W = 2 + SELW;
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = PTRW + 1;
    localparam logic [SELW:0] NUM_CH_W = (SELW+1)'(NUM_CH);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_OBSERVE = 2'b01,
        MODE_CAPTURE = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FILL, ST_DONE} state_e;

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    state_e           state_q, state_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mem [DEPTH];

    mode_e            mode;
    logic [SELW-1:0]  sel_raw, sel_eff;
    logic [WIDTH-1:0] ch_data;
    logic             ch_valid;
    logic             load;
    logic             wr_en, rd_en;

    assign load    = prb.inCfgLoad;
    assign mode    = mode_e'(cfg_q[CFG_W-1 -: 2]);
    assign sel_raw = cfg_q[SELW-1:0];
    assign sel_eff = ({1'b0, sel_raw} < NUM_CH_W) ? sel_raw : '0;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        ch_data  = '0;
        ch_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_eff == SELW'(k)) begin
                ch_data  = prb.inProbe[k*WIDTH +: WIDTH];
                ch_valid = prb.inProbeValid[k];
            end
        end
    end

    // A load in the same cycle as a shift commits the pre-shift shadow.
    always_comb begin
        shadow_d = shadow_q;
        if (prb.inCfgShift) shadow_d = {shadow_q[CFG_W-2:0], prb.inCfgData};
        cfg_d = load ? shadow_q : cfg_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (mode_e'(shadow_q[CFG_W-1 -: 2]) == MODE_CAPTURE) ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_q)
                ST_ARMED: if (ch_valid) state_d = ST_FILL;
                ST_FILL:  if (ch_valid && count_q == CNTW'(DEPTH-1)) state_d = ST_DONE;
                default:  ;
            endcase
        end
    end

    // Load takes priority over any write or read landing in the same cycle.
    always_comb begin
        wr_en   = !load && (state_q == ST_ARMED || state_q == ST_FILL) && ch_valid;
        rd_en   = !load && (state_q == ST_DONE) && prb.inReadEnable && (count_q != '0);
        data_d  = data_q;
        valid_d = 1'b0;
        if (load) begin
            data_d = '0;
        end else begin
            case (mode)
                MODE_OBSERVE: begin
                    data_d  = ch_data;
                    valid_d = ch_valid;
                end
                MODE_CAPTURE: begin
                    if (rd_en) begin
                        data_d  = mem[rd_ptr_q];
                        valid_d = 1'b1;
                    end
                end
                default: data_d = '0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = load ? '0 : wr_ptr_q + PTRW'(wr_en);
        rd_ptr_d = load ? '0 : rd_ptr_q + PTRW'(rd_en);
        count_d  = load ? '0 : count_q + CNTW'(wr_en) - CNTW'(rd_en);
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            shadow_q <= '0;
            cfg_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: the capture buffer has no reset; count/pointers define which entries are meaningful.
    always_ff @(posedge inClock) begin
        if (wr_en) mem[wr_ptr_q] <= ch_data;
    end

    assign prb.outData    = data_q;
    assign prb.outValid   = valid_q;
    assign prb.outEmpty   = (count_q == '0);
    assign prb.outFull    = (count_q == CNTW'(DEPTH));
    assign prb.outDone    = (state_q == ST_DONE);
    assign prb.outCfgEcho = shadow_q[CFG_W-1];
endmodule

// File: tb/tb_zb_probe_router.sv
// Directed bench for zb_probe_router: observe, capture/read-out, load priority, config chaining
// and asynchronous reset, with expected values worked out by hand.
module tb_zb_probe_router;
    localparam int NUM_CH = 8;
    localparam int WIDTH  = 4;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] sh;

    zb_probe_router_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) prb();

    zb_probe_router #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .inClock (clk),
        .inReset (rst_n),
        .prb     (prb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [3:0] d, input logic v);
        prb.inProbe[k*WIDTH +: WIDTH] = d;
        prb.inProbeValid[k]           = v;
    endtask

    task automatic shift_bits(input logic [4:0] bits);
        for (int i = 4; i >= 0; i--) begin
            prb.inCfgShift = 1'b1;
            prb.inCfgData  = bits[i];
            tick();
            sh = {sh[3:0], bits[i]};
            chk("echo_shift", {31'd0, prb.outCfgEcho}, {31'd0, sh[4]});
        end
        prb.inCfgShift = 1'b0;
        prb.inCfgData  = 1'b0;
    endtask

    task automatic load_cfg();
        prb.inCfgLoad = 1'b1;
        tick();
        prb.inCfgLoad = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  {28'd0, prb.outData},    32'h0);
        chk({tag, "_valid"}, {31'd0, prb.outValid},   32'h0);
        chk({tag, "_empty"}, {31'd0, prb.outEmpty},   32'h1);
        chk({tag, "_full"},  {31'd0, prb.outFull},    32'h0);
        chk({tag, "_done"},  {31'd0, prb.outDone},    32'h0);
        chk({tag, "_echo"},  {31'd0, prb.outCfgEcho}, 32'h0);
    endtask

    initial begin
        rst_n            = 1'b0;
        sh               = '0;
        prb.inCfgShift   = 1'b0;
        prb.inCfgData    = 1'b0;
        prb.inCfgLoad    = 1'b0;
        prb.inProbe      = '0;
        prb.inProbeValid = '0;
        prb.inReadEnable = 1'b0;

        // Reset state
        #12;
        chk_reset_outputs("reset");
        #1 rst_n = 1'b1;
        tick();
        chk_reset_outputs("idle_after_reset");

        // Observe channel 3
        shift_bits(5'b01_011);
        load_cfg();
        chk("obs_load_valid", {31'd0, prb.outValid}, 32'h0);
        prb.inProbe      = 32'h7654_A210;
        prb.inProbeValid = 8'b0000_1000;
        chk("obs_latency", {28'd0, prb.outData}, 32'h0);
        tick();
        chk("obs_data", {28'd0, prb.outData}, 32'hA);
        chk("obs_valid", {31'd0, prb.outValid}, 32'h1);
        set_ch(3, 4'h5, 1'b0);
        tick();
        chk("obs_data2", {28'd0, prb.outData}, 32'h5);
        chk("obs_valid2", {31'd0, prb.outValid}, 32'h0);

        // Capture on channel 2: five idle cycles, then 0..15
        shift_bits(5'b10_010);
        load_cfg();
        chk("cap_leave_obs_data", {28'd0, prb.outData}, 32'h0);
        chk("cap_leave_obs_valid", {31'd0, prb.outValid}, 32'h0);
        prb.inProbeValid = '0;
        set_ch(2, 4'h9, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("cap_armed_empty", {31'd0, prb.outEmpty}, 32'h1);
        chk("cap_armed_done", {31'd0, prb.outDone}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            set_ch(2, 4'(i), 1'b1);
            prb.inReadEnable = (i == 3);
            tick();
            if (i == 3) chk("cap_fill_read_ignored", {31'd0, prb.outValid}, 32'h0);
            if (i == 14) begin
                chk("cap_full_at_15", {31'd0, prb.outFull}, 32'h0);
                chk("cap_done_at_15", {31'd0, prb.outDone}, 32'h0);
            end
        end
        set_ch(2, 4'h0, 1'b0);
        prb.inReadEnable = 1'b0;
        chk("cap_full", {31'd0, prb.outFull}, 32'h1);
        chk("cap_done", {31'd0, prb.outDone}, 32'h1);
        chk("cap_not_empty", {31'd0, prb.outEmpty}, 32'h0);

        // Drain 0..15
        for (int i = 0; i < 16; i++) begin
            prb.inReadEnable = 1'b1;
            tick();
            chk("rd_data", {28'd0, prb.outData}, 32'(i));
            chk("rd_valid", {31'd0, prb.outValid}, 32'h1);
        end
        prb.inReadEnable = 1'b0;
        chk("rd_drained_empty", {31'd0, prb.outEmpty}, 32'h1);
        chk("rd_drained_done", {31'd0, prb.outDone}, 32'h1);
        prb.inReadEnable = 1'b1;
        tick();
        prb.inReadEnable = 1'b0;
        chk("rd_empty_valid", {31'd0, prb.outValid}, 32'h0);
        chk("rd_empty_empty", {31'd0, prb.outEmpty}, 32'h1);
        chk("rd_empty_full", {31'd0, prb.outFull}, 32'h0);

        // Re-arm, 7 writes, then load with simultaneous read and valid sample
        load_cfg();
        chk("rearm_done", {31'd0, prb.outDone}, 32'h0);
        chk("rearm_empty", {31'd0, prb.outEmpty}, 32'h1);
        for (int i = 0; i < 7; i++) begin
            set_ch(2, 4'(i + 1), 1'b1);
            tick();
        end
        chk("mid_fill_not_empty", {31'd0, prb.outEmpty}, 32'h0);
        set_ch(2, 4'hF, 1'b1);
        prb.inReadEnable = 1'b1;
        prb.inCfgLoad    = 1'b1;
        tick();
        prb.inCfgLoad    = 1'b0;
        prb.inReadEnable = 1'b0;
        set_ch(2, 4'hF, 1'b0);
        chk("midload_valid", {31'd0, prb.outValid}, 32'h0);
        chk("midload_empty", {31'd0, prb.outEmpty}, 32'h1);
        chk("midload_done", {31'd0, prb.outDone}, 32'h0);
        chk("midload_full", {31'd0, prb.outFull}, 32'h0);
        tick();
        tick();
        chk("midload_armed_waits", {31'd0, prb.outEmpty}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            set_ch(2, 4'(i) ^ 4'h5, 1'b1);
            tick();
        end
        set_ch(2, 4'h0, 1'b0);
        chk("refill_done", {31'd0, prb.outDone}, 32'h1);
        chk("refill_full", {31'd0, prb.outFull}, 32'h1);
        prb.inReadEnable = 1'b1;
        tick();
        chk("refill_rd0", {28'd0, prb.outData}, 32'h5);
        tick();
        chk("refill_rd1", {28'd0, prb.outData}, 32'h4);
        prb.inReadEnable = 1'b0;
        chk("refill_not_empty", {31'd0, prb.outEmpty}, 32'h0);

        // Shift and load together: load commits the pre-shift shadow (capture sel 2)
        prb.inCfgShift = 1'b1;
        prb.inCfgData  = 1'b1;
        prb.inCfgLoad  = 1'b1;
        tick();
        sh = {sh[3:0], 1'b1};
        prb.inCfgShift = 1'b0;
        prb.inCfgData  = 1'b0;
        prb.inCfgLoad  = 1'b0;
        chk("sl_echo", {31'd0, prb.outCfgEcho}, {31'd0, sh[4]});
        chk("sl_empty", {31'd0, prb.outEmpty}, 32'h1);
        chk("sl_done", {31'd0, prb.outDone}, 32'h0);
        set_ch(2, 4'h7, 1'b1);
        tick();
        set_ch(2, 4'h7, 1'b0);
        chk("sl_preshift_capture", {31'd0, prb.outEmpty}, 32'h0);

        // Observe ch5 via shift+load; shadow moves on to reserved mode 11
        shift_bits(5'b01_101);
        prb.inCfgShift = 1'b1;
        prb.inCfgData  = 1'b1;
        prb.inCfgLoad  = 1'b1;
        tick();
        sh = {sh[3:0], 1'b1};
        prb.inCfgShift = 1'b0;
        prb.inCfgData  = 1'b0;
        prb.inCfgLoad  = 1'b0;
        chk("sl2_echo", {31'd0, prb.outCfgEcho}, {31'd0, sh[4]});
        chk("sl2_load_data", {28'd0, prb.outData}, 32'h0);
        set_ch(5, 4'hC, 1'b1);
        tick();
        chk("sl2_obs_data", {28'd0, prb.outData}, 32'hC);
        chk("sl2_obs_valid", {31'd0, prb.outValid}, 32'h1);
        set_ch(3, 4'hA, 1'b1);
        load_cfg();
        tick();
        chk("rsvd_data", {28'd0, prb.outData}, 32'h0);
        chk("rsvd_valid", {31'd0, prb.outValid}, 32'h0);
        prb.inProbeValid = '0;

        // Asynchronous reset in the middle of a fill
        shift_bits(5'b10_010);
        load_cfg();
        for (int i = 0; i < 3; i++) begin
            set_ch(2, 4'(i + 3), 1'b1);
            tick();
        end
        chk("pre_rst_empty", {31'd0, prb.outEmpty}, 32'h0);
        chk("pre_rst_echo", {31'd0, prb.outCfgEcho}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        sh = '0;
        chk_reset_outputs("async_rst");
        #2 rst_n = 1'b1;
        prb.inProbeValid = '0;
        tick();
        chk_reset_outputs("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
